program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer-side counterpart to the instruction fetch path.
- Receives a byte-serial program image over a valid/ready stream, assembles 16-bit instruction words and writes them into the 4096 x 16 instruction memory through a write port.
- Holds the processor (fetch/PC) in reset until the image is completely loaded, then releases it.
- Sits between the host byte interface (UART receiver or testbench) and the instruction memory.

Parameters:
- ADDR_W, 12, instruction memory address width (depth = 2**ADDR_W words).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  incoming stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  one-cycle instruction memory write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  16  write data.
- cpu_hold  output  1  keep processor/fetch in reset while high.
- load_done  output  1  image loaded successfully; sticky until reset.
- load_err  output  1  framing/length/checksum error; sticky until the next sync byte or reset.

Behaviour:
- Byte transfer occurs when in_valid && in_ready at posedge clk. No other byte is consumed.
- Frame format:
  - SYNC_BYTE.
  - LEN_HI, LEN_LO: 16-bit word count N.
  - N words, each sent high byte first.
  - CSUM byte (only with the optional feature).
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0. The FSM enters SYNC.
- in_ready: 1 in SYNC, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM and ERROR. 0 in DONE and during the reset cycle.
- FSM states and transitions:
  - SYNC: sync byte -> LEN_HI. Any other byte is discarded and the FSM stays in SYNC.
  - LEN_HI -> LEN_LO on accept.
  - LEN_LO: N is latched on accept.
    - N==0 or N>2**ADDR_W -> ERROR.
    - Otherwise -> DATA_HI, with the word index cleared to 0.
  - DATA_HI: latch the high byte -> DATA_LO.
  - DATA_LO: on accept, register mem_we=1, mem_addr=index, mem_wdata={hi,lo}. These are visible the cycle after acceptance, and mem_we is high for exactly one cycle. The index then increments.
    - If the index was N-1 -> CSUM (feature on) or DONE (feature off).
    - Otherwise -> DATA_HI.
  - DONE: cpu_hold=0, load_done=1, in_ready=0. Stays here until reset. Further bytes are ignored (never accepted).
  - ERROR: cpu_hold=1, load_err=1. A sync byte clears load_err and goes to LEN_HI. Other bytes are discarded.
- cpu_hold deasserts in the same cycle load_done asserts. This is the cycle after the last word's mem_we (feature off), or after CSUM acceptance (feature on).
- Words already written before an error stay in memory. No rollback.
- Boundary conditions:
  - N = 2**ADDR_W: the last write goes to address 4095. The index never wraps.
  - A sync-valued byte inside LEN/DATA/CSUM states is treated as ordinary data.
  - in_valid gaps of any length mid-frame are legal. State is held.
  - Reset in the middle of a frame aborts it and returns all outputs to reset values on the next edge. Partially written memory is not cleared.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: after the last data byte the FSM enters CSUM and expects one byte equal to the XOR of all 2N data bytes.
  - Match -> DONE.
  - Mismatch -> ERROR. Memory writes have already happened, but cpu_hold stays 1.
- Undefined: no CSUM state and no checksum logic. The frame ends after the last data byte.

Test Plan:
- Reset, then send A5 00 02 12 34 AB CD (plus CSUM 40 if feature on) -> mem_we pulses with (addr 0, 1234) and (addr 1, ABCD). load_done=1, cpu_hold=0, in_ready=0 next cycle.
- Send 00 FF A5 00 01 BE EF (+ CSUM 51) -> leading 00 and FF discarded. Single write (addr 0, BEEF). Done.
- Send A5 00 00 -> load_err=1, cpu_hold=1. Then A5 00 01 00 01 (+ CSUM 01) -> load_err clears, write (0, 0001), done.
- Send A5 10 01 -> ERROR (N=4097 exceeds depth). Also a full 4096-word frame -> last write at addr 4095, no wrap, done.
- Random in_valid gaps (0-5 cycles) across a 3-word frame -> identical writes and final state as the gap-free run.
- Assert reset after 1.5 words -> all outputs return to reset values. A fresh frame then loads normally.
- [LOADER_CHECKSUM_EN] A5 00 01 12 34 with CSUM 00 -> load_err=1, cpu_hold stays 1, load_done=0.

Source files
------------

// File: rtl/program_loader.sv
// program_loader
// ----------------------------------------------------------------------------
// Byte-serial program image loader. It receives a framed image over a
// valid/ready byte stream, assembles 16-bit instruction words (high byte
// first), and writes them into the instruction memory through a one-cycle
// write strobe. The processor is held in reset until the image has been
// loaded completely.
//
// Frame: SYNC_BYTE, LEN_HI, LEN_LO, N words (hi, lo), [CSUM].
//
// Optional build macro:
//   LOADER_CHECKSUM_EN - after the last data byte one extra byte is expected.
//                        It must equal the XOR of all 2N data bytes; on a
//                        mismatch the loader goes to ERROR and the CPU stays held.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous, active-high reset
//   in_data    incoming stream byte
//   in_valid   in_data is valid this cycle
//   in_ready   loader accepts a byte this cycle (registered)
//   mem_we     one-cycle instruction memory write strobe
//   mem_addr   write address
//   mem_wdata  write data
//   cpu_hold   keep processor/fetch in reset while high
//   load_done  image loaded; sticky until reset
//   load_err   framing/length/checksum error; sticky until next sync or reset
// ----------------------------------------------------------------------------
module program_loader #(
    parameter int          ADDR_W    = 12,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    // Memory depth, one bit wider than the word count so 2**16 would still fit.
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    typedef enum logic [2:0] {
        ST_SYNC    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM    = 3'd5,
`endif
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    // Running checksum: XOR of every data byte seen in the current frame.
    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    logic [7:0] csum_r;
`endif

    state_t            state_r;
    logic [7:0]        len_hi_r;
    logic [15:0]       len_r;
    logic [7:0]        hi_r;
    logic [ADDR_W-1:0] idx_r;

    logic              in_ready_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [15:0]       mem_wdata_r;
    logic              cpu_hold_r;
    logic              load_done_r;
    logic              load_err_r;

    logic              accept_s;
    logic [15:0]       len_s;
    logic              len_bad_s;
    logic              last_s;

    assign accept_s  = in_valid && in_ready_r;
    assign len_s     = {len_hi_r, in_data};
    assign len_bad_s = (len_s == 16'd0) || ({1'b0, len_s} > DEPTH);
    // Index never exceeds N-1, so the last word is detected without wrapping.
    assign last_s    = (16'(idx_r) == (len_r - 16'd1));

    // Frame FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_SYNC;
            len_hi_r    <= 8'd0;
            len_r       <= 16'd0;
            hi_r        <= 8'd0;
            idx_r       <= '0;
            in_ready_r  <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 16'd0;
            cpu_hold_r  <= 1'b1;
            load_done_r <= 1'b0;
            load_err_r  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_r      <= 8'd0;
`endif
        end else begin
            mem_we_r   <= 1'b0;
            // Ready everywhere except DONE; transitions into DONE drop it at once
            // so no byte can slip in on the following edge.
            in_ready_r <= 1'b1;
            case (state_r)
                ST_SYNC: begin
                    if (accept_s && (in_data == SYNC_BYTE)) begin
                        state_r <= ST_LEN_HI;
`ifdef LOADER_CHECKSUM_EN
                        csum_r  <= 8'd0;
`endif
                    end
                end
                ST_LEN_HI: begin
                    if (accept_s) begin
                        len_hi_r <= in_data;
                        state_r  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (accept_s) begin
                        len_r <= len_s;
                        if (len_bad_s) begin
                            state_r    <= ST_ERROR;
                            load_err_r <= 1'b1;
                        end else begin
                            state_r <= ST_DATA_HI;
                            idx_r   <= '0;
                        end
                    end
                end
                ST_DATA_HI: begin
                    if (accept_s) begin
                        hi_r    <= in_data;
                        state_r <= ST_DATA_LO;
`ifdef LOADER_CHECKSUM_EN
                        csum_r  <= csum_next(csum_r, in_data);
`endif
                    end
                end
                ST_DATA_LO: begin
                    if (accept_s) begin
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= idx_r;
                        mem_wdata_r <= {hi_r, in_data};
`ifdef LOADER_CHECKSUM_EN
                        csum_r      <= csum_next(csum_r, in_data);
`endif
                        if (last_s) begin
`ifdef LOADER_CHECKSUM_EN
                            state_r    <= ST_CSUM;
`else
                            state_r    <= ST_DONE;
                            in_ready_r <= 1'b0;
`endif
                        end else begin
                            idx_r   <= idx_r + ADDR_W'(1);
                            state_r <= ST_DATA_HI;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (accept_s) begin
                        if (in_data == csum_r) begin
                            state_r     <= ST_DONE;
                            in_ready_r  <= 1'b0;
                            cpu_hold_r  <= 1'b0;
                            load_done_r <= 1'b1;
                        end else begin
                            state_r    <= ST_ERROR;
                            load_err_r <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    in_ready_r  <= 1'b0;
                    cpu_hold_r  <= 1'b0;
                    load_done_r <= 1'b1;
                end
                ST_ERROR: begin
                    if (accept_s && (in_data == SYNC_BYTE)) begin
                        load_err_r <= 1'b0;
                        state_r    <= ST_LEN_HI;
`ifdef LOADER_CHECKSUM_EN
                        csum_r     <= 8'd0;
`endif
                    end
                end
                default: begin
                    state_r <= ST_SYNC;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_hold  = cpu_hold_r;
    assign load_done = load_done_r;
    assign load_err  = load_err_r;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: a cycle-by-cycle vector table with
// hand-computed expected outputs, plus sequences for gaps, the full-depth
// image and mid-frame reset.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    always #5 clk = ~clk;

    program_loader #(.ADDR_W(12), .SYNC_BYTE(8'hA5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One row = inputs for one clock edge and the outputs expected just after it.
    typedef struct {
        logic        rst;
        logic        v;
        logic [7:0]  d;
        logic        we;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic        rdy;
        logic        hold;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic v, input logic [7:0] d, input logic we,
                       input logic [11:0] a, input logic [15:0] x, input logic rdy,
                       input logic hold, input logic done, input logic err);
        vec_t e;
        e.rst = r; e.v = v; e.d = d; e.we = we; e.addr = a; e.wdata = x;
        e.rdy = rdy; e.hold = hold; e.done = done; e.err = err;
        vq.push_back(e);
    endtask

    task automatic rst_rows();
        add(1'b1, 1'b0, 8'h00, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic b(input logic [7:0] d);
        add(1'b0, 1'b1, d, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic be(input logic [7:0] d);
        add(1'b0, 1'b1, d, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic w(input logic [7:0] d, input logic [11:0] a, input logic [15:0] x);
        add(1'b0, 1'b1, d, 1'b1, a, x, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // Last data byte, optional checksum byte, one idle cycle, then a byte in DONE that must be ignored.
    task automatic last_word(input logic [7:0] d, input logic [11:0] a, input logic [15:0] x,
                             input logic [7:0] cs);
`ifdef LOADER_CHECKSUM_EN
        add(1'b0, 1'b1, d, 1'b1, a, x, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, cs, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
`else
        add(1'b0, 1'b1, d, 1'b1, a, x, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
        add(1'b0, 1'b0, 8'h00, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 8'hA5, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Write log captured away from the active edge.
    logic [11:0] wa[$];
    logic [15:0] wd[$];

    // Record every memory write strobe.
    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        wa.delete();
        wd.delete();
    endtask

    // Present one byte until it is accepted; bounded wait. Called at a negedge.
    task automatic send_byte(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        in_data = d;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            ok = in_ready;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input logic [15:0] words[$], input int maxgap);
        logic [7:0] cs;
        logic [15:0] n;
        cs = 8'h00;
        n = 16'(words.size());
        send_byte(8'hA5);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        foreach (words[i]) begin
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
            send_byte(words[i][15:8]);
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
            send_byte(words[i][7:0]);
            cs = cs ^ words[i][15:8] ^ words[i][7:0];
        end
`ifdef LOADER_CHECKSUM_EN
        repeat ($urandom_range(0, maxgap)) @(negedge clk);
        send_byte(cs);
`endif
    endtask

    task automatic wait_done();
        for (int k = 0; k < 20 && !load_done; k++) @(negedge clk);
        chk("done_reached", 32'(load_done), 32'd1);
        chk("done_hold", 32'(cpu_hold), 32'd0);
        chk("done_err", 32'(load_err), 32'd0);
        chk("done_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        logic [15:0] g3[$];
        logic [15:0] full[$];
        int bad;

        // Two-word image
        rst_rows();
        b(8'hA5); b(8'h00); b(8'h02); b(8'h12);
        w(8'h34, 12'h000, 16'h1234);
        b(8'hAB);
        last_word(8'hCD, 12'h001, 16'hABCD, 8'h40);
        // Leading junk discarded, single word
        rst_rows();
        b(8'h00); b(8'hFF); b(8'hA5); b(8'h00); b(8'h01); b(8'hBE);
        last_word(8'hEF, 12'h000, 16'hBEEF, 8'h51);
        // N=0 error, then recovery with a new sync
        rst_rows();
        b(8'hA5); b(8'h00);
        be(8'h00);
        be(8'h00);
        b(8'hA5); b(8'h00); b(8'h01); b(8'h00);
        last_word(8'h01, 12'h000, 16'h0001, 8'h01);
        // N=4097 exceeds depth
        rst_rows();
        b(8'hA5); b(8'h10);
        be(8'h01);
        be(8'h00);
        // Reset after 1.5 words, then a fresh frame
        rst_rows();
        b(8'hA5); b(8'h00); b(8'h03); b(8'h11);
        w(8'h22, 12'h000, 16'h1122);
        b(8'h33);
        rst_rows();
        b(8'hA5); b(8'h00); b(8'h01); b(8'hCA);
        last_word(8'hFE, 12'h000, 16'hCAFE, 8'h34);
`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: writes happen but CPU stays held
        rst_rows();
        b(8'hA5); b(8'h00); b(8'h01); b(8'h12);
        w(8'h34, 12'h000, 16'h1234);
        be(8'h00);
        add(1'b0, 1'b0, 8'h00, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
`endif

        foreach (vq[i]) begin
            @(negedge clk);
            reset = vq[i].rst;
            in_valid = vq[i].v;
            in_data = vq[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(vq[i].we));
            chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(vq[i].rdy));
            chk($sformatf("v%0d_hold", i), 32'(cpu_hold), 32'(vq[i].hold));
            chk($sformatf("v%0d_done", i), 32'(load_done), 32'(vq[i].done));
            chk($sformatf("v%0d_err", i), 32'(load_err), 32'(vq[i].err));
            if (vq[i].we || vq[i].rst) begin
                chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vq[i].addr));
                chk($sformatf("v%0d_wdata", i), 32'(mem_wdata), 32'(vq[i].wdata));
            end
        end
        in_valid = 1'b0;

        // Three-word frame with sync-valued data bytes, gap-free then with gaps
        g3.push_back(16'hA5A5);
        g3.push_back(16'h0102);
        g3.push_back(16'h00A5);
        for (int run = 0; run < 2; run++) begin
            do_reset();
            send_frame(g3, (run == 0) ? 0 : 5);
            wait_done();
            chk($sformatf("gap%0d_nwrites", run), 32'(wa.size()), 32'd3);
            if (wa.size() == 3) begin
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("gap%0d_addr%0d", run, i), 32'(wa[i]), 32'(i));
                    chk($sformatf("gap%0d_data%0d", run, i), 32'(wd[i]), 32'(g3[i]));
                end
            end
        end

        // Full-depth image: last write at 4095, no wrap
        for (int i = 0; i < 4096; i++) full.push_back(16'(i * 3) ^ 16'h5A3C);
        do_reset();
        send_frame(full, 0);
        wait_done();
        chk("full_nwrites", 32'(wa.size()), 32'd4096);
        if (wa.size() == 4096) begin
            bad = 0;
            for (int i = 0; i < 4096; i++) begin
                if (wa[i] !== 12'(i) || wd[i] !== full[i]) bad++;
            end
            chk("full_seq_errs", 32'(bad), 32'd0);
            chk("full_last_addr", 32'(wa[4095]), 32'hFFF);
            chk("full_last_data", 32'(wd[4095]), 32'(full[4095]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
